// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter with lockable bursts in front of a single-port RAM
// Ports: clk/reset (sync, active-high); per port reqN, weN, lockN, addrN, wdataN in, gntN and rvalidN out;
// rdata = ram_q; ram_addr/ram_data/ram_we drive the RAM, ram_q is its registered-address read data.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    logic prio, owner_valid, owner, rd_port_valid, rd_port;
    logic locked, sel_we, sel_lock, acc;
    always_comb begin
        // a lock only binds while its owner keeps requesting; dropping req frees the RAM this cycle
        locked   = owner_valid && (owner ? req1 : req0);
        gnt0     = !reset && req0 && (locked ? !owner : (!req1 || !prio));
        gnt1     = !reset && req1 && (locked ? owner : (!req0 || prio));
        acc      = gnt0 || gnt1;
        ram_addr = gnt1 ? addr1 : addr0;
        ram_data = gnt1 ? wdata1 : wdata0;
        sel_we   = gnt1 ? we1 : we0;
        sel_lock = gnt1 ? lock1 : lock0;
        ram_we   = acc && sel_we;
        // reset suppresses the strobe of a read accepted just before it
        rvalid0  = !reset && rd_port_valid && !rd_port;
        rvalid1  = !reset && rd_port_valid && rd_port;
        rdata    = ram_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prio          <= 1'b0;
            owner_valid   <= 1'b0;
            owner         <= 1'b0;
            rd_port_valid <= 1'b0;
            rd_port       <= 1'b0;
        end else begin
            rd_port_valid <= acc && !sel_we;
            rd_port       <= gnt1;
            if (acc) begin
                prio        <= gnt0;
                owner_valid <= sel_lock;
                owner       <= gnt1;
            end else if (!locked) begin
                owner_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus constrained-random run against a reference model
module tb_ram_arbiter;
    logic clk = 1'b0, rst;
    logic req0, req1, we0, we1, lock0, lock1;
    logic [5:0] addr0, addr1, ram_addr;
    logic [31:0] wdata0, wdata1, rdata, ram_data, ram_q;
    logic gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [31:0] mem [64];
    logic [5:0] ra;
    int n_chk = 0, n_fail = 0;

    ram_arbiter dut (
        .clk(clk), .reset(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM: registered read address, reset reloads a known pattern
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        else if (ram_we) mem[ram_addr] <= ram_data;
        ra <= ram_addr;
    end
    assign ram_q = mem[ra];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // ctl = {rst,req0,req1,we0,we1,lock0,lock1}; exp = {gnt0,gnt1,rvalid0,rvalid1,check_rdata}
    typedef struct {
        logic [6:0]  ctl;
        logic [5:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [4:0]  exp;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [6:0] ctl, input logic [5:0] a0, input logic [5:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] exp,
                                input logic [31:0] rd);
        vec_t v;
        v.ctl = ctl; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.exp = exp; v.rd = rd;
        tbl.push_back(v);
    endfunction

    bit [1:0] p_req, p_we, p_lock, eg, ev;
    logic [5:0] p_addr [2];
    logic [31:0] p_wd [2];
    logic [31:0] ref_mem [64];
    logic [31:0] edata;
    int wt [2];
    bit m_prio, m_ov, m_own, lk, gi;

    initial begin
        {rst, req0, req1, we0, we1, lock0, lock1} = 7'b1000000;
        {addr0, addr1, wdata0, wdata1} = '0;
        // reset, both held requesting
        add(7'b1110000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00000, 32'h0);
        add(7'b1110000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00000, 32'h0);
        // alternating reads of addr 5 / 9
        add(7'b0110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b10000, 32'h0);
        add(7'b0110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b01101, 32'h1000_0005);
        add(7'b0110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b10011, 32'h1000_0009);
        add(7'b0110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b01101, 32'h1000_0005);
        add(7'b0000000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00011, 32'h1000_0009);
        // write then read of same address from the other port
        add(7'b0101000, 6'd3,  6'd0,  32'hDEADBEEF, 32'h0, 5'b10000, 32'h0);
        add(7'b0010000, 6'd0,  6'd3,  32'h0, 32'h0, 5'b01000, 32'h0);
        add(7'b0000000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00011, 32'hDEADBEEF);
        // port 0 write hands prio to port 1, then port 1 locked 4-beat burst while req0 waits
        add(7'b0101000, 6'd10, 6'd0,  32'h11, 32'h0, 5'b10000, 32'h0);
        add(7'b0110101, 6'd12, 6'd20, 32'h0, 32'h1, 5'b01000, 32'h0);
        add(7'b0110101, 6'd12, 6'd21, 32'h0, 32'h2, 5'b01000, 32'h0);
        add(7'b0110101, 6'd12, 6'd22, 32'h0, 32'h3, 5'b01000, 32'h0);
        add(7'b0110100, 6'd12, 6'd23, 32'h0, 32'h4, 5'b01000, 32'h0);
        add(7'b0100000, 6'd12, 6'd0,  32'h0, 32'h0, 5'b10000, 32'h0);
        add(7'b0000000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00101, 32'h1000_000C);
        // port 0 locks (beats port 1 despite prio), then drops req: port 1 granted same cycle
        add(7'b0100010, 6'd1,  6'd0,  32'h0, 32'h0, 5'b10000, 32'h0);
        add(7'b0110010, 6'd1,  6'd2,  32'h0, 32'h0, 5'b10101, 32'h1000_0001);
        add(7'b0010000, 6'd0,  6'd2,  32'h0, 32'h0, 5'b01101, 32'h1000_0001);
        add(7'b0000000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00011, 32'h1000_0002);
        // read accepted, then reset: no rvalid; afterwards req1 alone wins, prio back to port 0
        add(7'b0100000, 6'd5,  6'd0,  32'h0, 32'h0, 5'b10000, 32'h0);
        add(7'b1110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b00000, 32'h0);
        add(7'b0010000, 6'd0,  6'd9,  32'h0, 32'h0, 5'b01000, 32'h0);
        add(7'b0110000, 6'd5,  6'd9,  32'h0, 32'h0, 5'b10011, 32'h1000_0009);
        add(7'b0000000, 6'd0,  6'd0,  32'h0, 32'h0, 5'b00101, 32'h1000_0005);
        @(posedge clk); #1;
        foreach (tbl[k]) begin
            {rst, req0, req1, we0, we1, lock0, lock1} = tbl[k].ctl;
            {addr0, addr1, wdata0, wdata1} = {tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1};
            #2;
            chk("gnt0", k, 32'(gnt0), 32'(tbl[k].exp[4]));
            chk("gnt1", k, 32'(gnt1), 32'(tbl[k].exp[3]));
            chk("rvalid0", k, 32'(rvalid0), 32'(tbl[k].exp[2]));
            chk("rvalid1", k, 32'(rvalid1), 32'(tbl[k].exp[1]));
            if (tbl[k].exp[0]) chk("rdata", k, rdata, tbl[k].rd);
            @(posedge clk); #1;
        end
        // random phase on addresses 32..39, reference memory mirrors the reset pattern
        {rst, req0, req1} = 3'b100;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
        {m_prio, m_ov, m_own, p_req, ev} = '0;
        wt[0] = 0; wt[1] = 0; edata = '0;
        for (int c = 0; c < 10000; c++) begin
            {req0, req1, we0, we1, lock0, lock1} = {p_req[0], p_req[1], p_we[0], p_we[1], p_lock[0], p_lock[1]};
            {addr0, addr1, wdata0, wdata1} = {p_addr[0], p_addr[1], p_wd[0], p_wd[1]};
            #2;
            lk = m_ov && (m_own ? p_req[1] : p_req[0]);
            eg[0] = p_req[0] && (lk ? !m_own : (!p_req[1] || !m_prio));
            eg[1] = p_req[1] && (lk ? m_own : (!p_req[0] || m_prio));
            chk("rnd_gnt", c, 32'({gnt0, gnt1}), 32'({eg[0], eg[1]}));
            chk("rnd_rvalid", c, 32'({rvalid0, rvalid1}), 32'({ev[0], ev[1]}));
            if (ev != 0) chk("rnd_rdata", c, rdata, edata);
            for (int i = 0; i < 2; i++) begin
                wt[i] = (p_req[i] && !eg[i] && !m_ov) ? wt[i] + 1 : 0;
                if (wt[i] > 0) chk("rnd_wait", c, 32'(wt[i] > 1), 32'(0));
            end
            gi = eg[1];
            ev = '0;
            if (eg != 0) begin
                if (p_we[gi]) ref_mem[p_addr[gi]] = p_wd[gi];
                else begin
                    ev[gi] = 1'b1;
                    edata = ref_mem[p_addr[gi]];
                end
                m_prio = !gi;
                m_ov = p_lock[gi];
                m_own = gi;
            end else if (m_ov && !lk) m_ov = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (eg[i] || !p_req[i]) begin
                    p_req[i]  = ($urandom % 4) != 0;
                    p_we[i]   = 1'($urandom % 2);
                    p_lock[i] = ($urandom % 4) == 0;
                    p_addr[i] = 6'(32 + $urandom % 8);
                    p_wd[i]   = $urandom;
                end else if ($urandom % 16 == 0) p_req[i] = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
